// File: rtl/astar_pkg.sv
// Shared A* engine definitions: coordinate/cost typedefs, direction
// encoding with its (dx,dy) offset tables, default step costs and the
// neighbour-expander FSM state encoding. No ports (package).
package astar_pkg;

   localparam int COORD_W_DEF   = 16;
   localparam int G_W_DEF       = 32;
   localparam int COST_ORTH_DEF = 10;
   localparam int COST_DIAG_DEF = 14;   // ~10*sqrt(2)

   typedef logic [2:0]               dir_t;
   typedef logic [COORD_W_DEF-1:0]   coord_t;
   typedef logic [G_W_DEF-1:0]       cost_t;

   localparam dir_t DIR_LAST = 3'd7;

   // Unit offset along one axis: neg = -1, pos = +1, neither = 0.
   typedef struct packed {
      logic neg;
      logic pos;
   } off_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WAIT,
      ST_EMIT,
      ST_DONE
   } state_t;

   // Direction order: 0 E, 1 NE, 2 N, 3 NW, 4 W, 5 SW, 6 S, 7 SE (y grows southwards).
   function automatic off_t dir_dx(dir_t d);
      off_t o;
      o = '0;
      case (d)
         3'd0, 3'd1, 3'd7: o.pos = 1'b1;
         3'd3, 3'd4, 3'd5: o.neg = 1'b1;
         default:          o = '0;
      endcase
      return o;
   endfunction

   function automatic off_t dir_dy(dir_t d);
      off_t o;
      o = '0;
      case (d)
         3'd1, 3'd2, 3'd3: o.neg = 1'b1;
         3'd5, 3'd6, 3'd7: o.pos = 1'b1;
         default:          o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/neighbor_expander.sv
// Purpose : walks the 8 grid neighbours of one popped node, drops out-of-grid and
//           obstacle cells via the obstacle map, emits survivors with g' = g + step.
// Latency : accept T0, map read T1, load T2, nb_valid T3; 3 cycles per emitted
//           neighbour, 1 per out-of-grid dir, 2 per obstacle dir.
// Backpr. : nb_valid/nb_ready handshake; while nb_ready is low the block holds in
//           EMIT with nb_* stable and issues no map reads. node_ready only in IDLE.
// Ports   : clk/rst_n (sync, active-low); node_valid/node_ready/node_x/node_y/node_g
//           parent in; map_rd_en/map_rd_addr out, map_rd_data in (1-cycle latency);
//           nb_valid/nb_ready/nb_x/nb_y/nb_g/nb_dir neighbour out; done/done_count.
module neighbor_expander
   import astar_pkg::*;
#(
   parameter int GRID_W    = 32,
   parameter int GRID_H    = 32,
   parameter int COORD_W   = COORD_W_DEF,
   parameter int G_W       = G_W_DEF,
   parameter int COST_ORTH = COST_ORTH_DEF,
   parameter int COST_DIAG = COST_DIAG_DEF,
   parameter bit DIAG_EN   = 1'b1,
   localparam int AW       = $clog2(GRID_W*GRID_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               node_valid,
   output logic               node_ready,
   input  logic [COORD_W-1:0] node_x,
   input  logic [COORD_W-1:0] node_y,
   input  logic [G_W-1:0]     node_g,
   output logic               map_rd_en,
   output logic [AW-1:0]      map_rd_addr,
   input  logic               map_rd_data,
   output logic               nb_valid,
   input  logic               nb_ready,
   output logic [COORD_W-1:0] nb_x,
   output logic [COORD_W-1:0] nb_y,
   output logic [G_W-1:0]     nb_g,
   output logic [2:0]         nb_dir,
   output logic               done,
   output logic [3:0]         done_count
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W-1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H-1);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, y_q;
   logic [G_W-1:0]     g_q;
   dir_t               dir_q;
   logic [3:0]         count_q;
   logic [COORD_W-1:0] nb_x_q, nb_y_q;
   logic [G_W-1:0]     nb_g_q;
   dir_t               nb_dir_q;

   off_t               dx, dy;
   logic               nb_oob, dir_dis, skip, last, node_oob;
   logic [COORD_W-1:0] nx, ny;
   logic [G_W:0]       step_cost, g_sum;
   logic [G_W-1:0]     g_sat;

   // ---------------- neighbour geometry and cost ----------------
   always_comb begin
      dx       = dir_dx(dir_q);
      dy       = dir_dy(dir_q);
      // Parent is known to be in-grid here, so only the edge cells can step out.
      nb_oob   = (dx.neg && (x_q == '0)) || (dx.pos && (x_q == X_MAX)) ||
                 (dy.neg && (y_q == '0)) || (dy.pos && (y_q == Y_MAX));
      dir_dis  = !DIAG_EN && dir_q[0];
      skip     = dir_dis || nb_oob;
      last     = (dir_q == DIR_LAST);
      nx       = dx.pos ? x_q + COORD_W'(1) : (dx.neg ? x_q - COORD_W'(1) : x_q);
      ny       = dy.pos ? y_q + COORD_W'(1) : (dy.neg ? y_q - COORD_W'(1) : y_q);
      // Odd directions are the diagonals.
      step_cost = dir_q[0] ? (G_W+1)'(COST_DIAG) : (G_W+1)'(COST_ORTH);
      g_sum     = {1'b0, g_q} + step_cost;
      g_sat     = g_sum[G_W] ? '1 : g_sum[G_W-1:0];
      node_oob  = (node_x > X_MAX) || (node_y > Y_MAX);
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (node_valid) state_d = node_oob ? ST_DONE : ST_CHECK;
         ST_CHECK: if (skip)       state_d = last ? ST_DONE : ST_CHECK;
                   else            state_d = ST_WAIT;
         ST_WAIT:  if (map_rd_data) state_d = last ? ST_DONE : ST_CHECK;
                   else             state_d = ST_EMIT;
         ST_EMIT:  if (nb_ready)   state_d = last ? ST_DONE : ST_CHECK;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      node_ready  = (state_q == ST_IDLE);
      map_rd_en   = (state_q == ST_CHECK) && !skip;
      map_rd_addr = '0;
      if (map_rd_en) map_rd_addr = AW'(32'(ny) * 32'(GRID_W) + 32'(nx));
      nb_valid    = (state_q == ST_EMIT);
      done        = (state_q == ST_DONE);
      done_count  = done ? count_q : 4'd0;
   end

   // ---------------- datapath ----------------
   // dir wraps 7 -> 0 on the final advance, leaving it ready for the next parent.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q      <= '0;
         y_q      <= '0;
         g_q      <= '0;
         dir_q    <= '0;
         count_q  <= '0;
         nb_x_q   <= '0;
         nb_y_q   <= '0;
         nb_g_q   <= '0;
         nb_dir_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (node_valid) begin
               x_q     <= node_x;
               y_q     <= node_y;
               g_q     <= node_g;
               dir_q   <= '0;
               count_q <= '0;
            end
            ST_CHECK: if (skip) dir_q <= dir_q + 3'd1;
            ST_WAIT: begin
               if (map_rd_data) begin
                  dir_q <= dir_q + 3'd1;
               end else begin
                  nb_x_q   <= nx;
                  nb_y_q   <= ny;
                  nb_g_q   <= g_sat;
                  nb_dir_q <= dir_q;
               end
            end
            ST_EMIT: if (nb_ready) begin
               count_q <= count_q + 4'd1;
               dir_q   <= dir_q + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign nb_x   = nb_x_q;
   assign nb_y   = nb_y_q;
   assign nb_g   = nb_g_q;
   assign nb_dir = nb_dir_q;

endmodule

// File: tb/tb_neighbor_expander.sv
// Bench for neighbor_expander: directed corner cases plus randomized parents and
// obstacle maps, checked by a scoreboard fed from a reference model of the
// neighbour rules. Ports: none.
module tb_neighbor_expander;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        node_valid = 1'b0;
   logic        node_ready;
   logic [15:0] node_x = '0, node_y = '0;
   logic [31:0] node_g = '0;
   logic        map_rd_en;
   logic [9:0]  map_rd_addr;
   logic        map_rd_data = 1'b0;
   logic        nb_valid;
   logic        nb_ready = 1'b1;
   logic [15:0] nb_x, nb_y;
   logic [31:0] nb_g;
   logic [2:0]  nb_dir;
   logic        done;
   logic [3:0]  done_count;

   always #5 clk = ~clk;

   neighbor_expander dut (
      .clk(clk), .rst_n(rst_n),
      .node_valid(node_valid), .node_ready(node_ready),
      .node_x(node_x), .node_y(node_y), .node_g(node_g),
      .map_rd_en(map_rd_en), .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
      .nb_valid(nb_valid), .nb_ready(nb_ready),
      .nb_x(nb_x), .nb_y(nb_y), .nb_g(nb_g), .nb_dir(nb_dir),
      .done(done), .done_count(done_count)
   );

   // Obstacle map: read data appears one cycle after the strobe.
   bit obs [0:1023];
   always @(posedge clk) map_rd_data <= map_rd_en ? obs[map_rd_addr] : 1'b0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct { int x; int y; logic [31:0] g; int dir; } nb_t;
   typedef struct { int cnt; int reads; int lat; } dn_t;
   nb_t exp_q[$];
   dn_t done_q[$];

   int          c0 = 0;
   int          reads_seen = 0;
   int          rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random
   logic        hold_prev = 1'b0;
   logic [15:0] hx, hy;
   logic [31:0] hg;
   logic [2:0]  hd;

   function automatic void chk(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void fail_now(string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endfunction

   // Reference model: neighbour list from the geometric rules, costs with saturation.
   task automatic model(int px, int py, logic [31:0] pg, int lat);
      int  dxs[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
      int  dys[8] = '{0, -1, -1, -1, 0, 1, 1, 1};
      int  cnt = 0;
      int  rd = 0;
      nb_t e;
      dn_t d;
      if (px >= 0 && px < 32 && py >= 0 && py < 32) begin
         for (int k = 0; k < 8; k++) begin
            int     nx;
            int     ny;
            longint s;
            nx = px + dxs[k];
            ny = py + dys[k];
            if (nx < 0 || nx > 31 || ny < 0 || ny > 31) continue;
            rd++;
            if (obs[ny*32 + nx]) continue;
            s = longint'(pg) + ((k % 2 == 1) ? 14 : 10);
            e.x = nx;
            e.y = ny;
            e.g = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
            e.dir = k;
            exp_q.push_back(e);
            cnt++;
         end
      end
      d.cnt = cnt;
      d.reads = rd;
      d.lat = lat;
      done_q.push_back(d);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (node_valid && node_ready) reads_seen = 0;
         if (map_rd_en) reads_seen++;
         if (hold_prev) begin
            chk("hold_valid", longint'(nb_valid), 1);
            chk("hold_xyd", {nb_x, nb_y, nb_dir}, {hx, hy, hd});
            chk("hold_g", nb_g, hg);
         end
         if (nb_valid && !nb_ready) begin
            chk("no_read_in_stall", longint'(map_rd_en), 0);
            hold_prev = 1'b1;
            hx = nb_x; hy = nb_y; hg = nb_g; hd = nb_dir;
         end else begin
            hold_prev = 1'b0;
         end
         if (nb_valid && nb_ready) begin
            if (exp_q.size() == 0) fail_now("nb_unexpected");
            else begin
               nb_t e;
               e = exp_q.pop_front();
               chk("nb_x", nb_x, e.x);
               chk("nb_y", nb_y, e.y);
               chk("nb_g", nb_g, e.g);
               chk("nb_dir", nb_dir, e.dir);
            end
         end
         if (done) begin
            if (done_q.size() == 0) fail_now("done_unexpected");
            else begin
               dn_t d;
               d = done_q.pop_front();
               chk("done_count", done_count, d.cnt);
               chk("map_reads", reads_seen, d.reads);
               chk("missing_nb", exp_q.size(), 0);
               if (d.lat >= 0) chk("done_latency", cyc - c0, d.lat);
            end
         end
      end else begin
         hold_prev = 1'b0;
      end
   end

   // nb_ready driver, updated just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       nb_ready = 1'b1;
            1:       nb_ready = 1'b0;
            default: nb_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send(int px, int py, logic [31:0] pg, int lat);
      int n = 0;
      model(px, py, pg, lat);
      @(posedge clk);
      #1;
      node_x = 16'(px);
      node_y = 16'(py);
      node_g = pg;
      node_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (node_ready) break;
         n++;
         if (n > 200) begin
            fail_now("accept_timeout");
            node_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      c0 = cyc;
      node_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (done_q.size() != 0) begin
         fail_now("done_timeout");
         exp_q.delete();
         done_q.delete();
      end
   endtask

   task automatic clear_map();
      for (int i = 0; i < 1024; i++) obs[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] rg;
      clear_map();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_node_ready", longint'(node_ready), 1);
      chk("rst_nb_valid", longint'(nb_valid), 0);
      chk("rst_map_rd_en", longint'(map_rd_en), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_done_count", done_count, 0);
      chk("rst_nb_g", nb_g, 0);
      chk("rst_nb_xy", {nb_x, nb_y, nb_dir}, 0);
      rst_n = 1'b1;

      // Centre parent, empty map: all 8, done at T0+25.
      rdy_mode = 0;
      send(5, 5, 32'd100, 24);
      wait_done();

      // Corner (0,0): only E, SE, S.
      send(0, 0, 32'd0, -1);
      wait_done();

      // Corner (31,31) with two obstacles.
      obs[31*32 + 30] = 1'b1;
      obs[30*32 + 30] = 1'b1;
      send(31, 31, 32'd500, -1);
      wait_done();
      clear_map();

      // Cost saturation.
      send(10, 10, 32'hFFFF_FFF8, -1);
      wait_done();

      // Parent outside the grid: immediate done with count 0.
      send(40, 5, 32'd7, 0);
      wait_done();

      // Stall the first EMIT for 10 cycles.
      rdy_mode = 1;
      send(3, 3, 32'd20, -1);
      n = 0;
      while (!nb_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!nb_valid) fail_now("stall_nb_valid_timeout");
      repeat (10) @(negedge clk);
      rdy_mode = 0;
      wait_done();

      // Random parents, obstacle maps and backpressure.
      rdy_mode = 2;
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 1024; i++) obs[i] = ($urandom_range(0, 3) == 0);
         rg = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                          : 32'($urandom);
         send(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rg, -1);
         wait_done();
      end
      rdy_mode = 0;
      clear_map();

      // Reset during WAIT of dir 3.
      send(10, 10, 32'd50, -1);
      n = 0;
      while (!(map_rd_en && map_rd_addr == 10'(9*32 + 9)) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("dir3_read_timeout");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_nb_valid", longint'(nb_valid), 0);
      chk("midrst_node_ready", longint'(node_ready), 1);
      chk("midrst_done", longint'(done), 0);
      exp_q.delete();
      done_q.delete();
      rst_n = 1'b1;
      send(20, 20, 32'd0, 24);
      wait_done();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
